// File: rtl/lfsr_offset_finder.sv
// Locates a captured LFSR word by replaying the generator's Fibonacci LFSR from a seed,
// one step per clock, and reports how many steps it took (or a timeout at MAX_ITER).
module lfsr_offset_finder #(
  parameter int WIDTH    = 17,
  parameter int MAX_ITER = 131071
) (
  input  logic             clk_72MHz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] polynomial,
  input  logic [WIDTH-1:0] start_data,
  input  logic [WIDTH-1:0] target,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] iteration_number
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(MAX_ITER - 1);
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_ITER);

  // Same step rule as the sequence generator, so offsets line up with its iterations.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] p);
    return {v[WIDTH-2:0], ^(v & p)};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] poly_r, poly_s;
  logic [WIDTH-1:0] seed_r, seed_s;
  logic [WIDTH-1:0] target_r, target_s;
  logic [WIDTH-1:0] value_r, value_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] iter_r, iter_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             found_r, found_s;

  // Next-state and next-value logic for the search sequencer.
  always_comb begin
    state_s  = state_r;
    poly_s   = poly_r;
    seed_s   = seed_r;
    target_s = target_r;
    value_s  = value_r;
    count_s  = count_r;
    iter_s   = iter_r;
    busy_s   = busy_r;
    found_s  = found_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          poly_s   = polynomial;
          seed_s   = start_data;
          target_s = target;
          busy_s   = 1'b1;
          state_s  = LOAD;
        end else begin
          state_s  = IDLE;
        end
      end
      LOAD: begin
        value_s = seed_r;
        count_s = ZERO_W;
        state_s = SEARCH;
      end
      SEARCH: begin
        if (value_r == target_r) begin
          found_s = 1'b1;
          iter_s  = count_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else if (count_r == LAST_CNT) begin
          found_s = 1'b0;
          iter_s  = MAX_CNT;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          value_s = lfsr_step(value_r, poly_r);
          count_s = count_r + ONE_W;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a running search.
  always_ff @(posedge clk_72MHz) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      poly_r   <= ZERO_W;
      seed_r   <= ZERO_W;
      target_r <= ZERO_W;
      value_r  <= ZERO_W;
      count_r  <= ZERO_W;
      iter_r   <= ZERO_W;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      found_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      poly_r   <= poly_s;
      seed_r   <= seed_s;
      target_r <= target_s;
      value_r  <= value_s;
      count_r  <= count_s;
      iter_r   <= iter_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      found_r  <= found_s;
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign found            = found_r;
  assign iteration_number = iter_r;

endmodule

// File: tb/tb_lfsr_offset_finder.sv
// Directed bench for lfsr_offset_finder; MAX_ITER is shortened so the timeout
// and last-iteration cases stay within a short run.
module tb_lfsr_offset_finder;

  localparam int W       = 17;
  localparam int TB_MAX  = 20000;
  localparam logic [W-1:0] POLY = 17'h1D258;
  localparam logic [W-1:0] SEED = 17'h00001;

  logic         clk_72MHz = 1'b0;
  logic         rst_n     = 1'b0;
  logic [W-1:0] polynomial = 17'h00000;
  logic [W-1:0] start_data = 17'h00000;
  logic [W-1:0] target     = 17'h00000;
  logic         start      = 1'b0;
  logic         busy, done, found;
  logic [W-1:0] iteration_number;

  int tests_run    = 0;
  int tests_failed = 0;

  lfsr_offset_finder #(.WIDTH(W), .MAX_ITER(TB_MAX)) dut (
    .clk_72MHz(clk_72MHz), .rst_n(rst_n), .polynomial(polynomial),
    .start_data(start_data), .target(target), .start(start), .busy(busy),
    .done(done), .found(found), .iteration_number(iteration_number)
  );

  always #7 clk_72MHz = ~clk_72MHz;

  // Reference generator: value after k steps from the seed.
  function automatic logic [W-1:0] gen_value(input logic [W-1:0] p, input logic [W-1:0] s,
                                             input int k);
    logic [W-1:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = {v[W-2:0], ^(v & p)};
    return v;
  endfunction

  // First iteration at which the target appears, or TB_MAX when it never does.
  function automatic int first_offset(input logic [W-1:0] p, input logic [W-1:0] s,
                                      input logic [W-1:0] t);
    logic [W-1:0] v;
    v = s;
    for (int k = 0; k < TB_MAX; k++) begin
      if (v == t) return k;
      v = {v[W-2:0], ^(v & p)};
    end
    return TB_MAX;
  endfunction

  task automatic launch(input logic [W-1:0] p, input logic [W-1:0] s, input logic [W-1:0] t);
    @(negedge clk_72MHz);
    polynomial = p; start_data = s; target = t; start = 1'b1;
    @(posedge clk_72MHz); #1;
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen (n0 = edges already elapsed since acceptance).
  task automatic wait_done(input int budget, input int n0, output int n, output int busy_cnt,
                           output bit ok);
    n = n0; busy_cnt = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk_72MHz); #1;
      n++;
      if (done) ok = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input string name, input bit ok, input int n, input int exp_k,
                              input bit exp_found);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL %s timeout: no done within budget (last edge %0d)", name, n);
    end else begin
      tests_run++;
      if (n !== exp_k + 2 && exp_found) begin
        tests_failed++; $display("FAIL %s latency: got %0d edges, expected %0d", name, n, exp_k + 2);
      end
      tests_run++;
      if (found !== exp_found) begin
        tests_failed++; $display("FAIL %s found: got %0b, expected %0b", name, found, exp_found);
      end
      tests_run++;
      if (iteration_number !== W'(exp_k)) begin
        tests_failed++; $display("FAIL %s iteration: got %0d, expected %0d", name, iteration_number, exp_k);
      end
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++; $display("FAIL %s busy at done: got %0b, expected 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_72MHz);
    #1;
    tests_run++;
    if ({busy, done, found, iteration_number} !== {3'b000, 17'h00000}) begin
      tests_failed++;
      $display("FAIL reset outputs: got busy=%0b done=%0b found=%0b iter=%0d, expected all 0",
               busy, done, found, iteration_number);
    end
    @(negedge clk_72MHz); rst_n = 1'b1;
  endtask

  task automatic test_offset_zero();
    int n, bc; bit ok;
    launch(POLY, SEED, 17'h00001);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL offset0 busy after accept: got %0b, expected 1", busy);
    end
    wait_done(10, 0, n, bc, ok);
    check_result("offset0", ok, n, 0, 1'b1);
    @(posedge clk_72MHz); #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL offset0 done pulse width: got done=%0b next cycle, expected 0", done);
    end
  endtask

  task automatic test_offsets();
    int n, bc, k; bit ok;
    // Iteration 5 worked by hand: 1,2,4,8,0x11,0x23.
    launch(POLY, SEED, 17'h00023);
    wait_done(20, 0, n, bc, ok);
    check_result("offset5", ok, n, 5, 1'b1);
    k = first_offset(POLY, SEED, gen_value(POLY, SEED, 1000));
    launch(POLY, SEED, gen_value(POLY, SEED, 1000));
    wait_done(1100, 0, n, bc, ok);
    check_result("offset1000", ok, n, k, 1'b1);
    k = first_offset(POLY, SEED, gen_value(POLY, SEED, TB_MAX - 1));
    launch(POLY, SEED, gen_value(POLY, SEED, TB_MAX - 1));
    wait_done(TB_MAX + 10, 0, n, bc, ok);
    check_result("offset_last", ok, n, k, 1'b1);
  endtask

  task automatic test_timeout();
    int n, bc; bit ok;
    launch(POLY, SEED, 17'h00000);
    wait_done(TB_MAX + 10, 0, n, bc, ok);
    check_result("timeout", ok, n, TB_MAX, 1'b0);
    tests_run++;
    if (n !== TB_MAX + 1) begin
      tests_failed++; $display("FAIL timeout latency: got %0d edges, expected %0d", n, TB_MAX + 1);
    end
    tests_run++;
    if (bc !== TB_MAX) begin
      tests_failed++; $display("FAIL timeout busy cycles: got %0d, expected %0d", bc, TB_MAX);
    end
  endtask

  task automatic test_ignore_inputs();
    int n, bc, k; bit ok, early;
    k = first_offset(POLY, SEED, gen_value(POLY, SEED, 300));
    launch(POLY, SEED, gen_value(POLY, SEED, 300));
    early = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_72MHz); #1;
      if (done) early = 1'b1;
      if (i == 10) begin start = 1'b1; target = 17'h00023; start_data = 17'h00004; end
      if (i == 11) start = 1'b0;
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++; $display("FAIL ignore early done: got 1, expected 0");
    end
    wait_done(400, 20, n, bc, ok);
    check_result("ignore", ok, n, k, 1'b1);
  endtask

  task automatic test_reset_mid_search();
    int n, bc; bit ok;
    launch(POLY, SEED, gen_value(POLY, SEED, 1000));
    repeat (50) @(posedge clk_72MHz);
    @(negedge clk_72MHz); rst_n = 1'b0;
    @(posedge clk_72MHz); #1;
    tests_run++;
    if ({busy, done, found, iteration_number} !== {3'b000, 17'h00000}) begin
      tests_failed++;
      $display("FAIL midreset outputs: got busy=%0b done=%0b found=%0b iter=%0d, expected all 0",
               busy, done, found, iteration_number);
    end
    @(negedge clk_72MHz); rst_n = 1'b1;
    wait_done(1100, 0, n, bc, ok);
    tests_run++;
    if (ok !== 1'b0) begin
      tests_failed++; $display("FAIL midreset stray done: got done at edge %0d, expected none", n);
    end
    launch(POLY, SEED, 17'h00023);
    wait_done(20, 0, n, bc, ok);
    check_result("after_reset", ok, n, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n, bc, k; bit ok;
    k = first_offset(POLY, SEED, gen_value(POLY, SEED, 1000));
    launch(POLY, SEED, 17'h00023);
    wait_done(20, 0, n, bc, ok);
    check_result("b2b_first", ok, n, 5, 1'b1);
    start = 1'b1; target = gen_value(POLY, SEED, 1000);
    @(posedge clk_72MHz); #1;
    start = 1'b0;
    tests_run++;
    if ({done, busy} !== 2'b01) begin
      tests_failed++; $display("FAIL b2b accept: got done=%0b busy=%0b, expected done=0 busy=1", done, busy);
    end
    wait_done(1100, 0, n, bc, ok);
    check_result("b2b_second", ok, n, k, 1'b1);
  endtask

  initial begin
    test_reset();
    test_offset_zero();
    test_offsets();
    test_timeout();
    test_ignore_inputs();
    test_reset_mid_search();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
